// File: rtl/mmio_io_hub.sv
// mmio_io_hub: memory-mapped I/O hub between the core load/store path and board peripherals.
//
// One 256-byte IO window at IO_BASE (addr[31:8] compared, addr[1:0] ignored):
//   0x00+4i OUT[i]  R/W   write-back output registers driving out_data/out_strobe
//   0x40+4i SNAP[i] RO    switch snapshots taken on conf_pulse, zero-extended
//   0x80    STATUS  R/W1  [0] conf_flag [1] nonempty [2] full [3] overflow [9:4] count;
//                         read clears conf_flag/overflow, write with wdata[4]=1 flushes FIFO
//   0x84    KEYPOP  RO    pops the keypad FIFO head (0 when empty)
//   0x88    KEYCNT  RO    FIFO occupancy
//   0x8C    IRQEN   R/W   only with MMIO_HUB_IRQ_EN defined (adds the irq output)
//
// Ports:
//   clk, rstn                       clock, asynchronous active-low reset
//   addr, rd_en, wr_en, wdata       core bus request
//   rdata, hit                      combinational load data and window hit
//   conf_pulse, in_data             snapshot trigger and live switch channels
//   key_valid, key_code             keypad push
//   out_data, out_strobe            registered outputs and one-cycle update strobes
//   irq                             registered interrupt (MMIO_HUB_IRQ_EN only)
//
// Optional feature macro: MMIO_HUB_IRQ_EN.

module mmio_io_hub #(
  parameter logic [31:0] IO_BASE    = 32'hFFFF_FC00,
  parameter int unsigned NUM_OUT    = 2,
  parameter int unsigned NUM_IN     = 1,
  parameter int unsigned IN_W       = 12,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [31:0]            addr,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic                   hit,
  input  logic                   conf_pulse,
  input  logic [NUM_IN*IN_W-1:0] in_data,
  input  logic                   key_valid,
  input  logic [3:0]             key_code,
  output logic [NUM_OUT*32-1:0]  out_data,
  output logic [NUM_OUT-1:0]     out_strobe
`ifdef MMIO_HUB_IRQ_EN
  ,
  output logic                   irq
`endif
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  // Word indices (addr[7:2]) of the fixed registers.
  localparam logic [5:0] WStatus = 6'h20;
  localparam logic [5:0] WKeyPop = 6'h21;
  localparam logic [5:0] WKeyCnt = 6'h22;
`ifdef MMIO_HUB_IRQ_EN
  localparam logic [5:0] WIrqEn  = 6'h23;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NUM_OUT*32-1:0] out_q;
  logic [NUM_OUT-1:0]    strobe_q;
  logic [IN_W-1:0]       snap_q [NUM_IN];
  logic                  conf_q, conf_d;
  logic                  ovf_q, ovf_d;
  logic [3:0]            fifo_q [FIFO_DEPTH];
  logic [PW-1:0]         wp_q, wp_d;
  logic [PW-1:0]         rp_q, rp_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [5:0] widx;
  logic       rd_act, wr_act;
  logic       unused_addr;

  assign widx        = addr[7:2];
  assign unused_addr = ^addr[1:0];
  assign hit         = (addr[31:8] == IO_BASE[31:8]);
  // A simultaneous read and write is a write only: no read data, no read side effect.
  assign rd_act      = rd_en & ~wr_en & hit;
  assign wr_act      = wr_en & hit;

  logic [NUM_OUT-1:0] out_wr;

  always_comb begin
    out_wr = '0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      out_wr[i] = wr_act & (widx == 6'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic fifo_full, fifo_nonempty;
  logic status_rd, pop, push, drop, flush;

  assign fifo_full     = (cnt_q == CW'(FIFO_DEPTH));
  assign fifo_nonempty = (cnt_q != '0);
  assign status_rd     = rd_act & (widx == WStatus);
  assign pop           = rd_act & (widx == WKeyPop) & fifo_nonempty;
  assign flush         = wr_act & (widx == WStatus) & wdata[4];
  // A pop in the same cycle frees the slot, so a push onto a full FIFO is not dropped.
  assign push          = key_valid & (~fifo_full | pop) & ~flush;
  assign drop          = key_valid & fifo_full & ~pop;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (flush) begin
      // Flush beats any concurrent push; read pointer catches up to write pointer.
      rp_d  = wp_q;
      cnt_d = '0;
    end else begin
      if (push) wp_d = wp_q + PW'(1);
      if (pop)  rp_d = rp_q + PW'(1);
      if (push && !pop)      cnt_d = cnt_q + CW'(1);
      else if (pop && !push) cnt_d = cnt_q - CW'(1);
    end
  end

  // Set beats clear for both sticky flags.
  assign conf_d = conf_pulse | (conf_q & ~status_rd);
  assign ovf_d  = drop | (ovf_q & ~status_rd);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q    <= '0;
      strobe_q <= '0;
      conf_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < NUM_IN; i++) snap_q[i] <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_OUT; i++) begin
        if (out_wr[i]) out_q[i*32 +: 32] <= wdata;
      end
      strobe_q <= out_wr;
      if (conf_pulse) begin
        for (int unsigned i = 0; i < NUM_IN; i++) snap_q[i] <= in_data[i*IN_W +: IN_W];
      end
      if (push) fifo_q[wp_q] <= key_code;
      conf_q <= conf_d;
      ovf_q  <= ovf_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_data   = out_q;
  assign out_strobe = strobe_q;

`ifdef MMIO_HUB_IRQ_EN
  logic [1:0] irqen_q;
  logic       irq_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irqen_q <= 2'b00;
      irq_q   <= 1'b0;
    end else begin
      if (wr_act && (widx == WIrqEn)) irqen_q <= wdata[1:0];
      irq_q <= (irqen_q[0] & conf_q) | (irqen_q[1] & fifo_nonempty);
    end
  end

  assign irq = irq_q;
`endif

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [31:0] status;
  logic [5:0]  cnt_field;

  assign cnt_field = 6'(cnt_q);

  always_comb begin
    status      = '0;
    status[0]   = conf_q;
    status[1]   = fifo_nonempty;
    status[2]   = fifo_full;
    status[3]   = ovf_q;
    status[9:4] = cnt_field;
  end

  always_comb begin
    rdata = '0;
    if (rd_act) begin
      for (int unsigned i = 0; i < NUM_OUT; i++) begin
        if (widx == 6'(i)) rdata = out_q[i*32 +: 32];
      end
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        if (widx == 6'(16 + i)) rdata = 32'(snap_q[i]);
      end
      case (widx)
        WStatus: rdata = status;
        WKeyPop: rdata = fifo_nonempty ? 32'(fifo_q[rp_q]) : 32'd0;
        WKeyCnt: rdata = 32'(cnt_q);
`ifdef MMIO_HUB_IRQ_EN
        WIrqEn:  rdata = 32'(irqen_q);
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_io_hub.sv
// Self-checking bench for mmio_io_hub (default parameters). A queue/array model computes
// expected outputs from the register-map rules; outputs are compared every cycle at the
// falling edge, plus literal expectations for the documented scenarios.

module tb_mmio_io_hub;

  localparam logic [31:0] BASE  = 32'hFFFF_FC00;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] addr = '0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        hit;
  logic        conf_pulse = 1'b0;
  logic [11:0] in_data = '0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = '0;
  logic [63:0] out_data;
  logic [1:0]  out_strobe;
`ifdef MMIO_HUB_IRQ_EN
  logic        irq;
`endif

  mmio_io_hub dut (
    .clk        (clk),
    .rstn       (rstn),
    .addr       (addr),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .wdata      (wdata),
    .rdata      (rdata),
    .hit        (hit),
    .conf_pulse (conf_pulse),
    .in_data    (in_data),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .out_data   (out_data),
    .out_strobe (out_strobe)
`ifdef MMIO_HUB_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [31:0] m_out [2];
  logic [1:0]  m_strobe;
  logic [11:0] m_snap;
  bit          m_conf, m_ovf, m_irq;
  logic [1:0]  m_irqen;
  logic [3:0]  m_q [$];

  task automatic model_reset();
    m_out[0] = '0;
    m_out[1] = '0;
    m_strobe = '0;
    m_snap   = '0;
    m_conf   = 0;
    m_ovf    = 0;
    m_irq    = 0;
    m_irqen  = '0;
    m_q.delete();
  endtask

  function automatic bit m_hit();
    return addr[31:8] == BASE[31:8];
  endfunction

  function automatic int cur_off();
    return int'(addr[7:0]) & 32'hFC;
  endfunction

  function automatic logic [31:0] exp_rdata();
    int off, sz;
    if (!(rd_en && !wr_en && m_hit())) return 32'd0;
    off = cur_off();
    sz  = m_q.size();
    if (off < 8) return m_out[off/4];
    if (off == 'h40) return {20'd0, m_snap};
    if (off == 'h80)
      return 32'(m_conf) | (32'(sz != 0) << 1) | (32'(sz == DEPTH) << 2) |
             (32'(m_ovf) << 3) | (32'(sz) << 4);
    if (off == 'h84) return (sz != 0) ? 32'(m_q[0]) : 32'd0;
    if (off == 'h88) return 32'(sz);
`ifdef MMIO_HUB_IRQ_EN
    if (off == 'h8C) return 32'(m_irqen);
`endif
    return 32'd0;
  endfunction

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic model_step();
    bit rd, wr, pop, flush, srd, drop;
    int off, sz;
    rd    = rd_en && !wr_en && m_hit();
    wr    = wr_en && m_hit();
    off   = cur_off();
    sz    = m_q.size();
    pop   = rd && off == 'h84 && sz > 0;
    srd   = rd && off == 'h80;
    flush = wr && off == 'h80 && wdata[4];
    drop  = key_valid && sz == DEPTH && !pop;
    m_irq = (m_irqen[0] && m_conf) || (m_irqen[1] && sz != 0);
    m_strobe = '0;
    if (wr && off < 8) begin
      m_out[off/4] = wdata;
      m_strobe[off/4] = 1'b1;
    end
`ifdef MMIO_HUB_IRQ_EN
    if (wr && off == 'h8C) m_irqen = wdata[1:0];
`endif
    if (pop) void'(m_q.pop_front());
    if (key_valid && !drop) m_q.push_back(key_code);
    if (flush) m_q.delete();
    m_conf = conf_pulse || (m_conf && !srd);
    m_ovf  = drop || (m_ovf && !srd);
    if (conf_pulse) m_snap = in_data;
  endtask

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("hit", 64'(hit), 64'(m_hit()));
    chk("rdata", 64'(rdata), 64'(exp_rdata()));
    chk("out_data", out_data, {m_out[1], m_out[0]});
    chk("out_strobe", 64'(out_strobe), 64'(m_strobe));
`ifdef MMIO_HUB_IRQ_EN
    chk("irq", 64'(irq), 64'(m_irq));
`endif
  endtask

  task automatic at_neg();
    @(negedge clk);
    compare_all();
  endtask

  task automatic finish_cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    at_neg();
    finish_cyc();
  endtask

  task automatic idle();
    rd_en = 0; wr_en = 0; addr = '0; wdata = '0;
    conf_pulse = 0; key_valid = 0; key_code = '0;
  endtask

  task automatic set_rd(input logic [7:0] off);
    idle();
    rd_en = 1;
    addr  = BASE | 32'(off);
  endtask

  task automatic set_wr(input logic [7:0] off, input logic [31:0] d);
    idle();
    wr_en = 1;
    addr  = BASE | 32'(off);
    wdata = d;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [7:0] offs [11];
    int r;
    offs = '{8'h00, 8'h04, 8'h08, 8'h40, 8'h44, 8'h80, 8'h84, 8'h88, 8'h8C, 8'h90, 8'hFC};
    r = $urandom_range(0, 12);
    if (r == 11) return $urandom();
    if (r == 12) return (BASE + 32'h100) | 32'($urandom_range(0, 255));
    return BASE | 32'(offs[r]) | 32'($urandom_range(0, 3));
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    model_reset();
    idle();
    #2;
    chk("reset_out_data", out_data, 64'd0);
    chk("reset_strobe", 64'(out_strobe), 64'd0);
    @(negedge clk);
    rstn = 1;
    @(posedge clk);
    #1;

    // Output register write and one-cycle strobe.
    set_wr(8'h04, 32'h0000_A5A5);
    step();
    idle();
    at_neg();
    chk("out1_value", 64'(out_data[63:32]), 64'h0000_A5A5);
    chk("out1_strobe", 64'(out_strobe), 64'b10);
    finish_cyc();
    at_neg();
    chk("out1_strobe_drop", 64'(out_strobe), 64'd0);
    finish_cyc();

    // Confirm snapshot and STATUS read-clear, then set-beats-clear.
    idle();
    in_data = 12'hABC;
    conf_pulse = 1;
    step();
    set_rd(8'h40);
    at_neg(); chk("snap0", 64'(rdata), 64'hABC); finish_cyc();
    set_rd(8'h80);
    at_neg(); chk("conf_set", 64'(rdata[0]), 64'd1); finish_cyc();
    set_rd(8'h80);
    at_neg(); chk("conf_cleared", 64'(rdata[0]), 64'd0); finish_cyc();
    set_rd(8'h80);
    conf_pulse = 1;
    step();
    set_rd(8'h80);
    at_neg(); chk("conf_set_beats_clear", 64'(rdata[0]), 64'd1); finish_cyc();

    // FIFO fill past depth, then drain.
    set_wr(8'h80, 32'h10);
    step();
    for (int k = 1; k <= 9; k++) begin
      idle(); key_valid = 1; key_code = 4'(k);
      step();
    end
    set_rd(8'h80);
    at_neg(); chk("fill_status", 64'(rdata & 32'h3FE), 64'h8E); finish_cyc();
    for (int k = 1; k <= 8; k++) begin
      set_rd(8'h84);
      at_neg(); chk("pop_order", 64'(rdata), 64'(k)); finish_cyc();
    end
    set_rd(8'h84);
    at_neg(); chk("pop_empty", 64'(rdata), 64'd0); finish_cyc();
    set_rd(8'h88);
    at_neg(); chk("keycnt_empty", 64'(rdata), 64'd0); finish_cyc();

    // Push + pop on full FIFO.
    for (int k = 0; k < 8; k++) begin
      idle(); key_valid = 1; key_code = 4'(k + 3);
      step();
    end
    set_rd(8'h84);
    key_valid = 1; key_code = 4'hF;
    at_neg(); chk("full_pushpop_head", 64'(rdata), 64'd3); finish_cyc();
    set_rd(8'h88);
    at_neg(); chk("full_pushpop_cnt", 64'(rdata), 64'd8); finish_cyc();
    set_rd(8'h80);
    at_neg(); chk("full_pushpop_ovf", 64'(rdata[3]), 64'd0); finish_cyc();

    // Push + pop on empty, then flush + push.
    set_wr(8'h80, 32'h10);
    step();
    set_rd(8'h84);
    key_valid = 1; key_code = 4'h5;
    at_neg(); chk("empty_pushpop_rd", 64'(rdata), 64'd0); finish_cyc();
    set_rd(8'h88);
    at_neg(); chk("empty_pushpop_cnt", 64'(rdata), 64'd1); finish_cyc();
    set_wr(8'h80, 32'h10);
    key_valid = 1; key_code = 4'h6;
    step();
    set_rd(8'h88);
    at_neg(); chk("flush_beats_push", 64'(rdata), 64'd0); finish_cyc();

`ifdef MMIO_HUB_IRQ_EN
    set_wr(8'h8C, 32'h2);
    step();
    idle(); key_valid = 1; key_code = 4'h7;
    step();
    idle();
    at_neg(); chk("irq_not_yet", 64'(irq), 64'd0); finish_cyc();
    at_neg(); chk("irq_set", 64'(irq), 64'd1); finish_cyc();
    set_rd(8'h84);
    step();
    idle();
    at_neg(); chk("irq_hold", 64'(irq), 64'd1); finish_cyc();
    at_neg(); chk("irq_clear", 64'(irq), 64'd0); finish_cyc();
`endif

    // Asynchronous reset mid-run: three entries queued, a strobe in flight.
    set_wr(8'h80, 32'h10);
    step();
    for (int k = 0; k < 3; k++) begin
      idle(); key_valid = 1; key_code = 4'(k + 1);
      if (k == 2) begin
        wr_en = 1; addr = BASE; wdata = 32'h1234_5678;
      end
      step();
    end
    idle();
    rstn = 0;
    #1;
    model_reset();
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_strobe", 64'(out_strobe), 64'd0);
`ifdef MMIO_HUB_IRQ_EN
    chk("rst_irq", 64'(irq), 64'd0);
`endif
    set_rd(8'h88);
    #1;
    chk("rst_keycnt", 64'(rdata), 64'd0);
    set_rd(8'h80);
    #1;
    chk("rst_status", 64'(rdata), 64'd0);
    @(negedge clk);
    idle();
    rstn = 1;
    @(posedge clk);
    #1;

    // Randomised traffic: a push-heavy phase then a read-heavy phase.
    for (int c = 0; c < 2000; c++) begin
      int kp, rp;
      kp = (c < 1000) ? 40 : 10;
      rp = (c < 1000) ? 35 : 60;
      idle();
      addr  = rand_addr();
      rd_en = $urandom_range(0, 99) < rp;
      wr_en = $urandom_range(0, 99) < 20;
      wdata = $urandom();
      if ($urandom_range(0, 5) != 0) wdata[4] = 1'b0;
      key_valid  = $urandom_range(0, 99) < kp;
      key_code   = 4'($urandom_range(0, 15));
      conf_pulse = $urandom_range(0, 99) < 10;
      in_data    = 12'($urandom());
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
